conv_sequencer: RTL and testbench
=================================

CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter KERNEL_SIZE, default 3, window edge; N = KERNEL_SIZE*KERNEL_SIZE elements.
REQ-003 SHALL have parameter CU_LATENCY, default 2, cycles from compute-unit operand presentation to product on cu_result (min 1).
REQ-004 SHALL have ports:
 clk  in  1  single clock, rising edge.
 reset  in  1  asynchronous, active-low reset.
 in_valid  in  1  window job offered.
 in_ready  out  1  block accepts job.
 filter  in  N*DATA_WIDTH  filter window, element i at [DATA_WIDTH*i +: DATA_WIDTH].
 image  in  N*DATA_WIDTH  image window, same packing.
 cu_a  out  DATA_WIDTH  filter operand to compute unit.
 cu_b  out  DATA_WIDTH  image operand to compute unit.
 cu_issue  out  1  cu_a/cu_b carry a valid pair this cycle.
 cu_result  in  DATA_WIDTH  product from compute unit.
 acc_clear  out  1  zero external accumulator.
 acc_en  out  1  accumulator adds acc_data this cycle.
 acc_data  out  DATA_WIDTH  equals cu_result (combinational pass-through).
 acc_value  in  DATA_WIDTH  accumulator contents (updated the cycle after acc_en).
 out_valid  out  1  result holds a finished window sum.
 out_ready  in  1  consumer takes result.
 result  out  DATA_WIDTH  registered window sum.
 busy  out  1  state != IDLE.

Function
REQ-005 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE; no other states.
REQ-006 SHALL assert in_ready only in IDLE; a job is accepted on the cycle in_valid && in_ready.
REQ-007 SHALL register filter and image on acceptance; later changes on those inputs have no effect on the current job.
REQ-008 SHALL enter ISSUE on acceptance, with index counter = 0 and acc_clear = 1 for exactly the first ISSUE cycle.
REQ-009 In ISSUE, SHALL each cycle drive cu_a/cu_b = latched element[index] and cu_issue = 1, then increment index; after index N-1, SHALL go to DRAIN.
REQ-010 SHALL drive cu_issue = 0 outside ISSUE, with cu_a/cu_b holding their last value.
REQ-011 SHALL delay cu_issue through a CU_LATENCY-deep valid shift register; acc_en = shift-register output, so exactly N acc_en pulses per job, each CU_LATENCY cycles after its issue.
REQ-012 SHALL stay in DRAIN exactly CU_LATENCY+1 cycles, then go to DONE and capture acc_value into result on that transition.
REQ-013 In DONE, SHALL hold out_valid = 1 and result stable until out_ready = 1; on that cycle it SHALL go to IDLE.
REQ-014 SHALL NOT accept a new job on the out_ready cycle; in_ready rises the following cycle (IDLE).
REQ-015 Latency: acceptance at cycle 0 gives issues at cycles 1..N, last acc_en at N+CU_LATENCY, and out_valid first high at cycle N+CU_LATENCY+3 (cycle 14 for defaults).
REQ-016 in_valid while busy SHALL be ignored without side effects.
REQ-017 Index and drain counters SHALL be sized to hold N and CU_LATENCY+1 without wrap.

Reset
REQ-018 On reset low, SHALL immediately set state = IDLE, counters = 0, valid shift register = 0, latched windows = 0, and these outputs = 0: cu_a, cu_b, cu_issue, acc_clear, acc_en, out_valid, result, busy.
REQ-019 Reset mid-job SHALL discard the job, producing no further acc_en or out_valid; in_ready = 1 on the first clock edge after reset releases.

Verification
REQ-020 Defaults, filter all 1, image = 1..9, out_ready=1, model accumulator: acceptance cycle 0 -> cu_issue at cycles 1-9 carrying pairs (1,1)..(1,9), acc_en at 3-11, out_valid at cycle 14, result = 45.
REQ-021 out_ready held low 5 cycles after out_valid -> result and out_valid stable throughout, in_ready = 0; single acceptance on release.
REQ-022 in_valid pulsed at cycles 3 and 12 of a job with different windows -> ignored; result unaffected; next job accepted only after IDLE.
REQ-023 Reset asserted at cycle 5 of ISSUE -> all outputs 0 at once, no acc_en afterwards, in_ready = 1 after release; next job gives correct sum.
REQ-024 KERNEL_SIZE=1, CU_LATENCY=1, filter 3, image 4 -> one issue, one acc_en, result = 12 at cycle 4.
REQ-025 Back-to-back jobs, in_valid held high -> second acceptance exactly 1 cycle after out_ready; exactly N acc_en per job, acc_clear once per job.

Source files
------------

// File: rtl/conv_sequencer.sv
// conv_sequencer: streams a KxK filter/image window pair through an external
// multiplier and accumulator, then presents the registered window sum.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready          : window job handshake (filter, image packed)
//   cu_a, cu_b, cu_issue       : operand pair to the compute unit
//   cu_result                  : product from the compute unit
//   acc_clear, acc_en, acc_data: external accumulator control/data
//   acc_value                  : accumulator contents
//   out_valid/out_ready, result: finished window sum handshake
//   busy                       : sequencer not idle
module conv_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int CU_LATENCY  = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] filter,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] image,
    output logic [DATA_WIDTH-1:0]                     cu_a,
    output logic [DATA_WIDTH-1:0]                     cu_b,
    output logic                                      cu_issue,
    input  logic [DATA_WIDTH-1:0]                     cu_result,
    output logic                                      acc_clear,
    output logic                                      acc_en,
    output logic [DATA_WIDTH-1:0]                     acc_data,
    input  logic [DATA_WIDTH-1:0]                     acc_value,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [DATA_WIDTH-1:0]                     result,
    output logic                                      busy
);

    localparam int N  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int IW = $clog2(N + 1);
    localparam int DW = $clog2(CU_LATENCY + 2);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [IW-1:0]           idx;
    logic [DW-1:0]           dcnt;
    logic [DATA_WIDTH-1:0]   filt_q [N];
    logic [DATA_WIDTH-1:0]   img_q  [N];
    logic [DATA_WIDTH-1:0]   sel_a;
    logic [DATA_WIDTH-1:0]   sel_b;
    logic [DATA_WIDTH-1:0]   hold_a;
    logic [DATA_WIDTH-1:0]   hold_b;
    logic [CU_LATENCY-1:0]   vsr;
    logic                    accept;

    assign accept = in_valid && (state == IDLE);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (accept) next_state = ISSUE;
            ISSUE: if (idx == IW'(N - 1)) next_state = DRAIN;
            DRAIN: if (dcnt == DW'(CU_LATENCY)) next_state = DONE;
            DONE:  if (out_valid && out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Element select from the latched windows
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                sel_a = filt_q[i];
                sel_b = img_q[i];
            end
        end
    end

    // Output logic; operands hold their last issued value outside ISSUE
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        cu_issue  = (state == ISSUE);
        acc_clear = (state == ISSUE) && (idx == '0);
        cu_a      = cu_issue ? sel_a : hold_a;
        cu_b      = cu_issue ? sel_b : hold_b;
        acc_en    = vsr[CU_LATENCY-1];
        acc_data  = cu_result;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                filt_q[i] <= '0;
                img_q[i]  <= '0;
            end
            idx       <= '0;
            dcnt      <= '0;
            hold_a    <= '0;
            hold_b    <= '0;
            vsr       <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < N; i++) begin
                    filt_q[i] <= filter[DATA_WIDTH*i +: DATA_WIDTH];
                    img_q[i]  <= image[DATA_WIDTH*i +: DATA_WIDTH];
                end
            end
            if (accept) begin
                idx <= '0;
            end else if (state == ISSUE) begin
                idx <= idx + 1'b1;
            end
            dcnt <= (state == DRAIN) ? dcnt + 1'b1 : '0;
            if (cu_issue) begin
                hold_a <= sel_a;
                hold_b <= sel_b;
            end
            // Issue flags travel alongside the compute-unit pipeline
            vsr <= (vsr << 1) | CU_LATENCY'(cu_issue);
            // Accumulator has absorbed the last product by the final DRAIN cycle
            if ((state == DRAIN) && (next_state == DONE)) begin
                result <= acc_value;
            end
            // Valid follows DONE entry by one cycle and drops on handshake
            out_valid <= (state == DONE) && !(out_valid && out_ready);
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: vector table, directed corner sequences and random jobs
// against a window-sum/timing model of the sequencer.
module tb_conv_sequencer;

    localparam int W  = 32;
    localparam int N  = 9;
    localparam int L  = 2;
    localparam int NW = N * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          in_valid, in_ready;
    logic [NW-1:0] filter, image;
    logic [W-1:0]  cu_a, cu_b, cu_result;
    logic          cu_issue, acc_clear, acc_en;
    logic [W-1:0]  acc_data, acc_value, result;
    logic          out_valid, out_ready, busy;

    logic          in_valid1, in_ready1;
    logic [W-1:0]  filter1, image1;
    logic [W-1:0]  cu_a1, cu_b1, cu_result1;
    logic          cu_issue1, acc_clear1, acc_en1;
    logic [W-1:0]  acc_data1, acc_value1, result1;
    logic          out_valid1, out_ready1, busy1;

    conv_sequencer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .filter(filter), .image(image),
        .cu_a(cu_a), .cu_b(cu_b), .cu_issue(cu_issue),
        .cu_result(cu_result),
        .acc_clear(acc_clear), .acc_en(acc_en),
        .acc_data(acc_data), .acc_value(acc_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    conv_sequencer #(.KERNEL_SIZE(1), .CU_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .filter(filter1), .image(image1),
        .cu_a(cu_a1), .cu_b(cu_b1), .cu_issue(cu_issue1),
        .cu_result(cu_result1),
        .acc_clear(acc_clear1), .acc_en(acc_en1),
        .acc_data(acc_data1), .acc_value(acc_value1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .result(result1), .busy(busy1)
    );

    // Compute unit and accumulator models
    logic [W-1:0] pipe0 [L];
    logic [W-1:0] pipe1;
    logic [W-1:0] acc0 = '0;
    logic [W-1:0] acc1 = '0;

    always @(posedge clk) begin
        pipe0[0] <= cu_a * cu_b;
        pipe0[1] <= pipe0[0];
        pipe1    <= cu_a1 * cu_b1;
        if (acc_clear) acc0 <= '0;
        else if (acc_en) acc0 <= acc0 + acc_data;
        if (acc_clear1) acc1 <= '0;
        else if (acc_en1) acc1 <= acc1 + acc_data1;
    end
    assign cu_result  = pipe0[L-1];
    assign cu_result1 = pipe1;
    assign acc_value  = acc0;
    assign acc_value1 = acc1;

    int en_cnt  = 0;
    int clr_cnt = 0;
    always @(posedge clk) begin
        if (acc_en) en_cnt <= en_cnt + 1;
        if (acc_clear) clr_cnt <= clr_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b", nm, act, exp);
        end
    endtask

    function automatic logic [NW-1:0] pk(input logic [W-1:0] base,
                                         input logic [W-1:0] step);
        logic [NW-1:0] v;
        for (int i = 0; i < N; i++) v[W*i +: W] = base + step * W'(i);
        return v;
    endfunction

    function automatic logic [W-1:0] dot(input logic [NW-1:0] f,
                                         input logic [NW-1:0] im);
        logic [W-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) s = s + f[W*i +: W] * im[W*i +: W];
        return s;
    endfunction

    // One job on the default instance; called and returns at a negedge.
    task automatic run_job(input logic [NW-1:0] f, input logic [NW-1:0] im,
                           input logic [W-1:0] exp, input int stall,
                           input bit pulse, input bit keep, input string tag);
        int t;
        int e0;
        int c0;
        int j;
        filter    = f;
        image     = im;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        t = 0;
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s accept_wait actual=timeout required=in_ready", tag);
            in_valid = 1'b0;
            return;
        end
        e0 = en_cnt;
        c0 = clr_cnt;
        for (int k = 1; k <= N + L + 3; k++) begin
            @(negedge clk);
            if (k == 1 && !keep) in_valid = 1'b0;
            if (pulse && (k == 3 || k == 12)) begin
                in_valid = 1'b1;
                filter   = ~f;
                image    = im ^ {NW{1'b1}};
            end else if (pulse && !keep && (k == 4 || k == 13)) begin
                in_valid = 1'b0;
            end
            chkb($sformatf("%s k%0d cu_issue", tag, k), cu_issue, k <= N);
            if (k <= N) begin
                chk($sformatf("%s k%0d cu_a", tag, k), cu_a, f[W*(k-1) +: W]);
                chk($sformatf("%s k%0d cu_b", tag, k), cu_b, im[W*(k-1) +: W]);
            end
            if (k == N + 1) begin
                chk($sformatf("%s hold cu_a", tag), cu_a, f[W*(N-1) +: W]);
                chk($sformatf("%s hold cu_b", tag), cu_b, im[W*(N-1) +: W]);
            end
            chkb($sformatf("%s k%0d acc_clear", tag, k), acc_clear, k == 1);
            chkb($sformatf("%s k%0d acc_en", tag, k), acc_en,
                 (k > L) && (k <= N + L));
            if (k > L && k <= N + L) begin
                j = k - L - 1;
                chk($sformatf("%s k%0d acc_data", tag, k), acc_data,
                    f[W*j +: W] * im[W*j +: W]);
            end
            chkb($sformatf("%s k%0d out_valid", tag, k), out_valid,
                 k == N + L + 3);
            chkb($sformatf("%s k%0d in_ready", tag, k), in_ready, 1'b0);
            chkb($sformatf("%s k%0d busy", tag, k), busy, 1'b1);
        end
        chk($sformatf("%s result", tag), result, exp);
        for (int s = 1; s <= stall; s++) begin
            @(negedge clk);
            chkb($sformatf("%s stall%0d out_valid", tag, s), out_valid, 1'b1);
            chk($sformatf("%s stall%0d result", tag, s), result, exp);
            chkb($sformatf("%s stall%0d in_ready", tag, s), in_ready, 1'b0);
            if (s == stall) out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        chkb($sformatf("%s post out_valid", tag), out_valid, 1'b0);
        chkb($sformatf("%s post in_ready", tag), in_ready, 1'b1);
        chkb($sformatf("%s post busy", tag), busy, 1'b0);
        chk($sformatf("%s acc_en count", tag), W'(en_cnt - e0), W'(N));
        chk($sformatf("%s acc_clear count", tag), W'(clr_cnt - c0), 32'd1);
    endtask

    typedef struct {
        logic [W-1:0] fb;
        logic [W-1:0] fs;
        logic [W-1:0] ib;
        logic [W-1:0] istep;
        logic [W-1:0] sum;
        int           stall;
        bit           pulse;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [NW-1:0] rf;
        logic [NW-1:0] ri;
        int t;
        int e0;

        tbl[0] = '{32'd1, 32'd0, 32'd1, 32'd1, 32'd45, 0, 1'b0};
        tbl[1] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd285, 5, 1'b1};
        tbl[2] = '{32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 1, 1'b0};
        tbl[3] = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 32'hFFFF_FFF7, 0, 1'b0};
        tbl[4] = '{32'd0, 32'd1, 32'd3, 32'd0, 32'd108, 2, 1'b0};

        reset      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        filter     = '0;
        image      = '0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        filter1    = '0;
        image1     = '0;

        #3;
        chk("rst cu_a", cu_a, '0);
        chk("rst cu_b", cu_b, '0);
        chkb("rst cu_issue", cu_issue, 1'b0);
        chkb("rst acc_clear", acc_clear, 1'b0);
        chkb("rst acc_en", acc_en, 1'b0);
        chkb("rst out_valid", out_valid, 1'b0);
        chk("rst result", result, '0);
        chkb("rst busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chkb("idle in_ready", in_ready, 1'b1);

        // 1x1 kernel, single-cycle compute unit
        filter1    = 32'd3;
        image1     = 32'd4;
        in_valid1  = 1'b1;
        out_ready1 = 1'b1;
        chkb("k1 in_ready", in_ready1, 1'b1);
        @(negedge clk);
        in_valid1 = 1'b0;
        chkb("k1 c1 cu_issue", cu_issue1, 1'b1);
        chk("k1 c1 cu_a", cu_a1, 32'd3);
        chk("k1 c1 cu_b", cu_b1, 32'd4);
        chkb("k1 c1 acc_clear", acc_clear1, 1'b1);
        @(negedge clk);
        chkb("k1 c2 cu_issue", cu_issue1, 1'b0);
        chkb("k1 c2 acc_en", acc_en1, 1'b1);
        chk("k1 c2 acc_data", acc_data1, 32'd12);
        @(negedge clk);
        chkb("k1 c3 acc_en", acc_en1, 1'b0);
        chkb("k1 c3 out_valid", out_valid1, 1'b0);
        @(negedge clk);
        chk("k1 c4 result", result1, 32'd12);
        @(negedge clk);
        chkb("k1 c5 out_valid", out_valid1, 1'b1);
        chk("k1 c5 result", result1, 32'd12);
        @(negedge clk);
        out_ready1 = 1'b0;
        chkb("k1 c6 out_valid", out_valid1, 1'b0);
        chkb("k1 c6 in_ready", in_ready1, 1'b1);

        // Vector table
        for (int r = 0; r < 5; r++) begin
            run_job(pk(tbl[r].fb, tbl[r].fs), pk(tbl[r].ib, tbl[r].istep),
                    tbl[r].sum, tbl[r].stall, tbl[r].pulse, 1'b0,
                    $sformatf("row%0d", r));
        end

        // Back-to-back with in_valid held high
        run_job(pk(32'd1, 32'd0), pk(32'd1, 32'd1), 32'd45, 0, 1'b0, 1'b1, "b2b0");
        run_job(pk(32'd0, 32'd1), pk(32'd3, 32'd0), 32'd108, 0, 1'b0, 1'b0, "b2b1");

        // Reset during ISSUE
        filter   = pk(32'd5, 32'd1);
        image    = pk(32'd7, 32'd2);
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
        end
        reset = 1'b0;
        #1;
        chk("mid_rst cu_a", cu_a, '0);
        chk("mid_rst cu_b", cu_b, '0);
        chkb("mid_rst cu_issue", cu_issue, 1'b0);
        chkb("mid_rst acc_clear", acc_clear, 1'b0);
        chkb("mid_rst acc_en", acc_en, 1'b0);
        chkb("mid_rst out_valid", out_valid, 1'b0);
        chk("mid_rst result", result, '0);
        chkb("mid_rst busy", busy, 1'b0);
        e0 = en_cnt;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            chkb($sformatf("post_rst c%0d acc_en", c), acc_en, 1'b0);
            chkb($sformatf("post_rst c%0d out_valid", c), out_valid, 1'b0);
            chkb($sformatf("post_rst c%0d in_ready", c), in_ready, 1'b1);
        end
        chk("post_rst acc_en count", W'(en_cnt - e0), '0);
        run_job(pk(32'd1, 32'd0), pk(32'd1, 32'd1), 32'd45, 0, 1'b0, 1'b0, "after_rst");

        // Random windows against the dot-product model
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                rf[W*i +: W] = $urandom();
                ri[W*i +: W] = $urandom();
            end
            run_job(rf, ri, dot(rf, ri), int'($urandom_range(0, 3)),
                    1'b0, 1'b0, $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
